// File: rtl/pattern_match_pkg.sv
// Shared state encoding and default parameter values for the serial pattern matcher.
// PATTERN_OVERLAP_EN selects overlapping match counting in pattern_shift_match.
package pattern_match_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        DONE = 2'd2,
        TOUT = 2'd3
    } state_t;

    localparam int PAT_W_DEFAULT   = 4;
    localparam int CNT_W_DEFAULT   = 8;
    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pattern_shift_match.sv
// Serial shift register, fill counter and pattern compare for pattern_match_ctrl.
// Build option PATTERN_OVERLAP_EN: keep the window after a match (overlapping matches).
module pattern_shift_match
    import pattern_match_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic             in_bit,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  sr;
    logic [PAT_W-1:0]  sr_next;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;

    // The match is judged on the post-shift window so it lands on the accepting edge.
    always_comb begin
        sr_next   = {sr[PAT_W-2:0], in_bit};
        fill_next = (fill == FULL) ? FULL : fill + FILL_W'(1);
        match     = accept && (fill_next == FULL) && (sr_next == pattern);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr   <= '0;
            fill <= '0;
        end else if (clear) begin
            sr   <= '0;
            fill <= '0;
        end else if (accept) begin
            sr <= sr_next;
`ifdef PATTERN_OVERLAP_EN
            fill <= fill_next;
`else
            fill <= match ? '0 : fill_next;
`endif
        end
    end

endmodule

// File: rtl/pattern_match_ctrl.sv
// Serial pattern match controller: arms on start, counts matches up to a target, aborts on inactivity.
// Build option PATTERN_OVERLAP_EN (see pattern_shift_match) enables overlapping matches.
module pattern_match_ctrl
    import pattern_match_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] match_target,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [1:0]       state,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             timeout_flag
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state_q;
    state_t            state_next;
    logic [PAT_W-1:0]  pat_q;
    logic [CNT_W-1:0]  target_q;
    logic [CNT_W-1:0]  count_next;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;
    logic              arm;
    logic              accept;
    logic              match;

    assign state        = state_q;
    assign in_ready     = (state_q == HUNT);
    assign done         = (state_q == DONE);
    assign timeout_flag = (state_q == TOUT);
    assign accept       = in_valid && in_ready;
    assign arm          = start && (state_q != HUNT);
    assign count_next   = (match_count == CNT_MAX) ? match_count : match_count + CNT_W'(1);
    assign timer_next   = timer + TMR_W'(1);

    pattern_shift_match #(
        .PAT_W(PAT_W)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .clear  (arm),
        .accept (accept),
        .in_bit (in_bit),
        .pattern(pat_q),
        .match  (match)
    );

    // A match implies an accept, which clears the timer, so match and timeout never collide.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE, DONE, TOUT: begin
                if (start) begin
                    state_next = (match_target == '0) ? DONE : HUNT;
                end
            end
            HUNT: begin
                if (match && (count_next == target_q)) begin
                    state_next = DONE;
                end else if (!accept && (timer_next == TMR_LIMIT)) begin
                    state_next = TOUT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            target_q    <= '0;
            match_count <= '0;
            timer       <= '0;
            match_pulse <= 1'b0;
        end else begin
            state_q     <= state_next;
            match_pulse <= match;
            if (arm) begin
                pat_q       <= pattern;
                target_q    <= match_target;
                match_count <= '0;
                timer       <= '0;
            end else if (state_q == HUNT) begin
                if (match) begin
                    match_count <= count_next;
                end
                timer <= accept ? '0 : timer_next;
            end
        end
    end

endmodule

// File: tb/tb_pattern_match_ctrl.sv
// Self-checking bench for pattern_match_ctrl: queue-based reference model plus pinned directed cases.
// Follows PATTERN_OVERLAP_EN the same way as the design build.
module tb_pattern_match_ctrl;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 8;
`ifdef PATTERN_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] match_target = '0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_ready;
    logic [1:0]       state;
    logic             match_pulse;
    logic [CNT_W-1:0] match_count;
    logic             done;
    logic             timeout_flag;

    int vectors = 0;
    int miscompares = 0;
    int pulses_seen = 0;

    // Reference model: state code, latched setup, and the window of accepted bits as a queue.
    int         m_state = 0;
    int         m_count = 0;
    int         m_timer = 0;
    bit         m_pulse = 1'b0;
    logic [3:0] m_pat = '0;
    logic [7:0] m_tgt = '0;
    bit         m_q[$];

    pattern_match_ctrl #(
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pattern     (pattern),
        .match_target(match_target),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .state       (state),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .done        (done),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit s, input logic [3:0] p,
                              input logic [7:0] t, input bit v, input bit b);
        int val;
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_timer = 0; m_pulse = 1'b0;
            m_pat = '0; m_tgt = '0; m_q.delete();
        end else if (m_state == 1) begin
            m_pulse = 1'b0;
            if (v) begin
                m_q.push_back(b);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                m_timer = 0;
                val = 0;
                foreach (m_q[i]) val = (val << 1) | int'(m_q[i]);
                if (m_q.size() == PAT_W && val == int'(m_pat)) begin
                    m_pulse = 1'b1;
                    if (m_count < 255) m_count++;
                    if (!OVL) m_q.delete();
                    if (m_count == int'(m_tgt)) m_state = 2;
                end
            end else begin
                m_timer++;
                if (m_timer == TIMEOUT) m_state = 3;
            end
        end else begin
            m_pulse = 1'b0;
            if (s) begin
                m_pat = p; m_tgt = t; m_q.delete();
                m_count = 0; m_timer = 0;
                m_state = (t == 0) ? 2 : 1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output just after the edge.
    task automatic applyStimulus(input bit rst_n, input bit s, input logic [3:0] p,
                                 input logic [7:0] t, input bit v, input bit b);
        reset = rst_n; start = s; pattern = p; match_target = t; in_valid = v; in_bit = b;
        model_step(rst_n, s, p, t, v, b);
        @(posedge clk);
        #1;
        if (match_pulse === 1'b1) pulses_seen++;
        checkOutput("state",        32'(state),        32'(m_state));
        checkOutput("in_ready",     32'(in_ready),     32'(m_state == 1));
        checkOutput("match_pulse",  32'(match_pulse),  32'(m_pulse));
        checkOutput("match_count",  32'(match_count),  32'(m_count));
        checkOutput("done",         32'(done),         32'(m_state == 2));
        checkOutput("timeout_flag", 32'(timeout_flag), 32'(m_state == 3));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 1'b0, 1'b0);
    endtask

    bit stream7 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit stream4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int pct;
        #1;
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 1'b0, 1'b0);
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_count", 32'(match_count), 32'd0);

        // Pattern 1001, target 3, stream 1001001; start asserted mid-HUNT must be ignored.
        applyStimulus(1'b1, 1'b1, 4'b1001, 8'd3, 1'b0, 1'b0);
        pulses_seen = 0;
        foreach (stream7[i]) applyStimulus(1'b1, 1'b1, 4'b0110, 8'd1, 1'b1, stream7[i]);
        checkOutput("ovl_count",  32'(match_count), OVL ? 32'd2 : 32'd1);
        checkOutput("ovl_pulses", 32'(pulses_seen), OVL ? 32'd2 : 32'd1);
        checkOutput("ovl_state",  32'(state), 32'd1);

        // Inactivity: still hunting after 7 idle cycles, aborted after the 8th.
        idle(7);
        checkOutput("tmo_before", 32'(state), 32'd1);
        idle(1);
        checkOutput("tmo_state", 32'(state), 32'd3);
        checkOutput("tmo_flag",  32'(timeout_flag), 32'd1);

        // Re-arm from TOUT with target 1; done follows the 4th accepted bit.
        applyStimulus(1'b1, 1'b1, 4'b1001, 8'd1, 1'b0, 1'b0);
        checkOutput("rearm_state", 32'(state), 32'd1);
        checkOutput("rearm_count", 32'(match_count), 32'd0);
        foreach (stream4[i]) applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 1'b1, stream4[i]);
        checkOutput("t1_done",  32'(done), 32'd1);
        checkOutput("t1_pulse", 32'(match_pulse), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 1'b1, 1'b1);
        checkOutput("t1_ready", 32'(in_ready), 32'd0);
        checkOutput("t1_hold",  32'(match_count), 32'd1);

        // Zero target goes straight to DONE and takes no bits.
        applyStimulus(1'b1, 1'b1, 4'b1111, 8'd0, 1'b1, 1'b1);
        checkOutput("t0_state", 32'(state), 32'd2);
        applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 1'b1, 1'b1);
        checkOutput("t0_count", 32'(match_count), 32'd0);

        // Reset after three accepted bits, then bits without start are refused.
        applyStimulus(1'b1, 1'b1, 4'b1111, 8'd5, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 8'h0, 1'b1, 1'b1);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_pulse", 32'(match_pulse), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h0, 8'h0, 1'b1, 1'b1);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_count", 32'(match_count), 32'd0);

        // Random traffic with phases of dense, medium and sparse validity.
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 3)
                0:       pct = 90;
                1:       pct = 50;
                default: pct = 5;
            endcase
            applyStimulus($urandom_range(0, 199) != 0,
                          $urandom_range(0, 9) == 0,
                          4'($urandom),
                          8'($urandom_range(0, 4)),
                          $urandom_range(0, 99) < pct,
                          1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
